// File: rtl/lcd_fb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : lcd_fb_pkg
// Brief   : Shared arbiter state encodings, wait-counter width, pixel packing.
// Revision: 1.0 - initial release
// ============================================================================
package lcd_fb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RD    = 2'd1,
        ST_WR    = 2'd2,
        ST_FORCE = 2'd3
    } arb_state_e;

    localparam int unsigned WAIT_W     = 8;

    // Frame-buffer word: four 10-bit components, Y0 in the low bits.
    localparam int unsigned PIX_COMP_W = 10;
    localparam int unsigned PIX_Y0_LSB = 0;
    localparam int unsigned PIX_Y1_LSB = 10;
    localparam int unsigned PIX_CB_LSB = 20;
    localparam int unsigned PIX_CR_LSB = 30;

    function automatic logic [4*PIX_COMP_W-1:0] pix_pack(
        input logic [PIX_COMP_W-1:0] y0,
        input logic [PIX_COMP_W-1:0] y1,
        input logic [PIX_COMP_W-1:0] cb,
        input logic [PIX_COMP_W-1:0] cr
    );
        return {cr, cb, y1, y0};
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_fb_starve_cnt.sv
`default_nettype none
// ============================================================================
// Module  : lcd_fb_starve_cnt
// Brief   : Saturating count of consecutive cycles a pending write was denied.
// Revision: 1.0 - initial release
// ============================================================================
module lcd_fb_starve_cnt
    import lcd_fb_pkg::*;
(
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              inc_i,
    output logic [WAIT_W-1:0] cnt_o
);

    localparam logic [WAIT_W-1:0] c_CNT_MAX = '1;

    logic [WAIT_W-1:0] cnt_q;
    logic [WAIT_W-1:0] cnt_d;

    // Any cycle that is not a denied pending write restarts the count.
    always_comb begin
        cnt_d = '0;
        if (inc_i) begin
            cnt_d = (cnt_q == c_CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/lcd_fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : lcd_fb_arbiter
// Brief   : Single-port frame-buffer BRAM arbiter, real-time reads vs writes.
// Revision: 1.0 - initial release
// ============================================================================
module lcd_fb_arbiter
    import lcd_fb_pkg::*;
#(
    parameter int W_WORD      = 18,
    parameter int W_PIX       = 40,
    parameter int MAX_WR_WAIT = 8
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              rd_urgent,
    input  logic              wr_req,
    input  logic [W_WORD-1:0] wr_addr,
    input  logic [W_PIX-1:0]  wr_data,
    output logic              wr_gnt,
    input  logic              rd_req,
    input  logic [W_WORD-1:0] rd_addr,
    output logic              rd_gnt,
    output logic              rd_valid,
    output logic [W_PIX-1:0]  rd_data,
    output logic              bram_en,
    output logic              bram_we,
    output logic [W_WORD-1:0] bram_addr,
    output logic [W_PIX-1:0]  bram_din,
    input  logic [W_PIX-1:0]  bram_dout,
    output logic              wr_starved
);

    localparam logic [WAIT_W-1:0] c_MAX_WAIT = WAIT_W'(MAX_WR_WAIT);

    arb_state_e        state_q;
    arb_state_e        state_d;
    logic [WAIT_W-1:0] w_wr_wait;
    logic              w_wr_win;
    logic              w_rd_win;
    logic              w_force;
    logic              rd_valid_q;
    logic              starved_q;

    lcd_fb_starve_cnt u_starve_cnt (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .inc_i   (wr_req & ~wr_gnt),
        .cnt_o   (w_wr_wait)
    );

    always_comb begin
        w_wr_win = 1'b0;
        w_rd_win = 1'b0;
        w_force  = 1'b0;
        state_d  = ST_IDLE;

        if (wr_req && !rd_req) begin
            w_wr_win = 1'b1;
        end else if (rd_req && !wr_req) begin
            w_rd_win = 1'b1;
        end else if (wr_req && rd_req) begin
            if (rd_urgent) begin
                // A forced write always yields the next slot back to the display.
                if ((state_q != ST_FORCE) && (w_wr_wait >= c_MAX_WAIT)) begin
                    w_wr_win = 1'b1;
                    w_force  = 1'b1;
                end else begin
                    w_rd_win = 1'b1;
                end
            end else if ((state_q == ST_RD) || (state_q == ST_IDLE)) begin
                w_wr_win = 1'b1;
            end else begin
                w_rd_win = 1'b1;
            end
        end

        if (w_force) begin
            state_d = ST_FORCE;
        end else if (w_wr_win) begin
            state_d = ST_WR;
        end else if (w_rd_win) begin
            state_d = ST_RD;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= ST_IDLE;
            rd_valid_q <= 1'b0;
            starved_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_valid_q <= rd_gnt;
            if (wr_gnt && w_force && rd_urgent) begin
                starved_q <= 1'b1;
            end
        end
    end

    // Grants are masked while reset is held so the BRAM sees no traffic.
    assign wr_gnt     = HRESETn & w_wr_win;
    assign rd_gnt     = HRESETn & w_rd_win;

    assign bram_en    = wr_gnt | rd_gnt;
    assign bram_we    = wr_gnt;
    assign bram_addr  = wr_gnt ? wr_addr : (rd_gnt ? rd_addr : '0);
    assign bram_din   = wr_gnt ? wr_data : '0;

    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_valid_q ? bram_dout : '0;
    assign wr_starved = starved_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_lcd_fb_arbiter
// Brief   : Scoreboard bench for lcd_fb_arbiter with reference arbitration model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_lcd_fb_arbiter;

    localparam int W_WORD      = 18;
    localparam int W_PIX       = 40;
    localparam int MAX_WR_WAIT = 8;

    logic              HCLK      = 1'b0;
    logic              HRESETn   = 1'b0;
    logic              rd_urgent = 1'b0;
    logic              wr_req    = 1'b0;
    logic [W_WORD-1:0] wr_addr   = '0;
    logic [W_PIX-1:0]  wr_data   = '0;
    logic              wr_gnt;
    logic              rd_req    = 1'b0;
    logic [W_WORD-1:0] rd_addr   = '0;
    logic              rd_gnt;
    logic              rd_valid;
    logic [W_PIX-1:0]  rd_data;
    logic              bram_en;
    logic              bram_we;
    logic [W_WORD-1:0] bram_addr;
    logic [W_PIX-1:0]  bram_din;
    logic [W_PIX-1:0]  bram_dout_q = '0;
    logic              wr_starved;

    lcd_fb_arbiter #(
        .W_WORD      (W_WORD),
        .W_PIX       (W_PIX),
        .MAX_WR_WAIT (MAX_WR_WAIT)
    ) dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .rd_urgent  (rd_urgent),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_gnt     (wr_gnt),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_gnt     (rd_gnt),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .bram_en    (bram_en),
        .bram_we    (bram_we),
        .bram_addr  (bram_addr),
        .bram_din   (bram_din),
        .bram_dout  (bram_dout_q),
        .wr_starved (wr_starved)
    );

    always #5 HCLK = ~HCLK;

    function automatic logic [W_PIX-1:0] pat(input logic [W_WORD-1:0] a);
        if (a == 18'h20) return 40'hABCDE;
        return {8'hC3, a, a[13:0]};
    endfunction

    // BRAM stand-in: 1-cycle read latency, content is a fixed address pattern.
    always @(posedge HCLK) begin
        if (bram_en && !bram_we) bram_dout_q <= pat(bram_addr);
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference model: 0=IDLE 1=RD 2=WR 3=FORCE.
    int               m_last    = 0;
    int               m_wait    = 0;
    bit               m_starved = 1'b0;
    logic [W_PIX-1:0] sb[$];
    int               n_rd_exp  = 0;
    int               n_rdvalid = 0;
    int               wr_lat    = 0;

    task automatic check_cycle();
        bit               ew, er, ef;
        logic [W_PIX-1:0] exp_d;
        ew = 1'b0; er = 1'b0; ef = 1'b0;
        if (!HRESETn) begin
            check("rst_wr_gnt",   64'(wr_gnt),     64'(0));
            check("rst_rd_gnt",   64'(rd_gnt),     64'(0));
            check("rst_bram_en",  64'(bram_en),    64'(0));
            check("rst_bram_adr", 64'(bram_addr),  64'(0));
            check("rst_rd_valid", 64'(rd_valid),   64'(0));
            check("rst_rd_data",  64'(rd_data),    64'(0));
            check("rst_starved",  64'(wr_starved), 64'(0));
            m_last = 0; m_wait = 0; m_starved = 1'b0;
            sb.delete();
            return;
        end
        if (sb.size() > 0) begin
            exp_d = sb.pop_front();
            check("rd_valid", 64'(rd_valid), 64'(1));
            check("rd_data",  64'(rd_data),  64'(exp_d));
        end else begin
            check("rd_valid_idle", 64'(rd_valid), 64'(0));
            check("rd_data_idle",  64'(rd_data),  64'(0));
        end
        if (rd_valid) n_rdvalid++;

        if (wr_req && !rd_req) ew = 1'b1;
        else if (rd_req && !wr_req) er = 1'b1;
        else if (wr_req && rd_req) begin
            if (rd_urgent) begin
                if (m_last != 3 && m_wait >= MAX_WR_WAIT) begin ew = 1'b1; ef = 1'b1; end
                else er = 1'b1;
            end else if (m_last == 1 || m_last == 0) ew = 1'b1;
            else er = 1'b1;
        end

        check("wr_gnt",    64'(wr_gnt),    64'(ew));
        check("rd_gnt",    64'(rd_gnt),    64'(er));
        check("bram_en",   64'(bram_en),   64'(ew | er));
        check("bram_we",   64'(bram_we),   64'(ew));
        check("bram_addr", 64'(bram_addr), ew ? 64'(wr_addr) : (er ? 64'(rd_addr) : 64'(0)));
        check("bram_din",  64'(bram_din),  ew ? 64'(wr_data) : 64'(0));
        check("starved",   64'(wr_starved), 64'(m_starved));

        if (er) begin
            sb.push_back(pat(rd_addr));
            n_rd_exp++;
        end
        m_last = ef ? 3 : (ew ? 2 : (er ? 1 : 0));
        m_wait = (wr_req && !ew) ? ((m_wait < 255) ? m_wait + 1 : 255) : 0;
        if (ef && rd_urgent) m_starved = 1'b1;
    endtask

    task automatic sample();
        @(negedge HCLK);
        check_cycle();
    endtask

    task automatic advance();
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        int rd_before;
        bit gw, gr;

        // Requests present during reset must not produce grants.
        wr_req = 1'b1; rd_req = 1'b1; rd_urgent = 1'b1;
        sample(); advance();
        sample(); advance();
        HRESETn = 1'b1; wr_req = 1'b0; rd_req = 1'b0; rd_urgent = 1'b0;
        sample(); advance();

        // Write only.
        wr_req = 1'b1; wr_addr = 18'h10; wr_data = 40'h12345;
        sample();
        check("w_only_gnt",  64'(wr_gnt),    64'(1));
        check("w_only_we",   64'(bram_we),   64'(1));
        check("w_only_addr", 64'(bram_addr), 64'(18'h10));
        check("w_only_din",  64'(bram_din),  64'(40'h12345));
        advance();
        wr_req = 1'b0;

        // Read only.
        rd_req = 1'b1; rd_addr = 18'h20;
        sample();
        check("r_only_gnt", 64'(rd_gnt), 64'(1));
        advance();
        rd_req = 1'b0;
        sample();
        check("r_only_valid", 64'(rd_valid), 64'(1));
        check("r_only_data",  64'(rd_data),  64'(40'hABCDE));
        advance();

        // Round-robin from IDLE, non-urgent.
        wr_req = 1'b1; rd_req = 1'b1; rd_urgent = 1'b0; rd_addr = 18'h33;
        for (int i = 0; i < 8; i++) begin
            sample();
            check("rr_wr", 64'(wr_gnt), 64'((i % 2) == 0));
            check("rr_rd", 64'(rd_gnt), 64'((i % 2) == 1));
            advance();
        end
        check("rr_starved", 64'(wr_starved), 64'(0));
        wr_req = 1'b0; rd_req = 1'b0;
        sample(); advance();

        // Urgent reads starve writes until the wait limit forces one through.
        wr_req = 1'b1; rd_req = 1'b1; rd_urgent = 1'b1; rd_addr = 18'h44;
        rd_before = 0;
        for (int i = 0; i < 10; i++) begin
            sample();
            if (i < MAX_WR_WAIT) begin
                check("urg_rd", 64'(rd_gnt), 64'(1));
                if (rd_gnt) rd_before++;
            end else if (i == MAX_WR_WAIT) begin
                check("urg_force_wr", 64'(wr_gnt), 64'(1));
            end else begin
                check("urg_after_force_rd", 64'(rd_gnt), 64'(1));
            end
            advance();
        end
        check("urg_rd_count", 64'(rd_before),  64'(8));
        check("urg_starved",  64'(wr_starved), 64'(1));

        // Reset one cycle after a read grant discards the in-flight read.
        wr_req = 1'b0; rd_urgent = 1'b0; rd_addr = 18'h5;
        sample();
        check("rst_mid_gnt", 64'(rd_gnt), 64'(1));
        advance();
        rd_req = 1'b0; HRESETn = 1'b0;
        #1;
        check("rst_mid_valid_drop", 64'(rd_valid), 64'(0));
        sample(); advance();
        HRESETn = 1'b1; wr_req = 1'b1; rd_req = 1'b1; rd_urgent = 1'b0;
        sample();
        check("post_rst_wr_first", 64'(wr_gnt), 64'(1));
        advance();

        // Random traffic; requesters hold until granted.
        wr_req = 1'b0; rd_req = 1'b0;
        sample(); advance();
        n_rd_exp = 0; n_rdvalid = 0; wr_lat = 0;
        for (int i = 0; i < 10000; i++) begin
            sample();
            gw = wr_gnt; gr = rd_gnt;
            check("one_grant", 64'(wr_gnt & rd_gnt), 64'(0));
            if (wr_req) begin
                wr_lat++;
                if (wr_gnt) begin
                    check("wr_latency", 64'(wr_lat <= MAX_WR_WAIT + 1), 64'(1));
                    wr_lat = 0;
                end
            end
            advance();
            if (!wr_req || gw) begin
                wr_req  = 1'($urandom_range(0, 1));
                wr_addr = W_WORD'($urandom);
                wr_data = W_PIX'({$urandom, $urandom});
            end
            if (!rd_req || gr) begin
                rd_req  = 1'($urandom_range(0, 1));
                rd_addr = W_WORD'($urandom);
            end
            rd_urgent = ($urandom_range(0, 3) != 0);
        end
        wr_req = 1'b0; rd_req = 1'b0;
        sample(); advance();
        sample(); advance();
        check("rd_valid_count", 64'(n_rdvalid), 64'(n_rd_exp));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
